multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the NPC RV32I core. Fetches one instruction at a time over a valid/ack handshake and holds it in the instruction register. It drives the immediate-generator format select (ExtOp) from that register and sequences the ALU, data memory, register-file write-back and PC update through one state per phase. It sits between instruction/data memory and the datapath, and is the only source of datapath write strobes.

---
 rtl/npc_ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_decode.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | npc_ctrl_pkg: shared types/encodings for the NPC multicycle ctrl  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_LUI    = 4'd1,
    CL_AUIPC  = 4'd2,
    CL_JAL    = 4'd3,
    CL_JALR   = 4'd4,
    CL_BRANCH = 4'd5,
    CL_LOAD   = 4'd6,
    CL_STORE  = 4'd7,
    CL_OPIMM  = 4'd8,
    CL_OP     = 4'd9
  } iclass_t;

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;

  localparam logic [31:0] C_INSTR_EBREAK = 32'h0010_0073;

  // Immediate format codes, shared with the immediate generator
  localparam logic [2:0] C_EXT_I = 3'b000;
  localparam logic [2:0] C_EXT_U = 3'b001;
  localparam logic [2:0] C_EXT_S = 3'b010;
  localparam logic [2:0] C_EXT_B = 3'b011;
  localparam logic [2:0] C_EXT_J = 3'b100;

  localparam logic [1:0] C_WB_ALU  = 2'b00;
  localparam logic [1:0] C_WB_LOAD = 2'b01;
  localparam logic [1:0] C_WB_PC4  = 2'b10;

  localparam logic [1:0] C_PC_PLUS4  = 2'b00;
  localparam logic [1:0] C_PC_REL    = 2'b01;
  localparam logic [1:0] C_PC_JALR   = 2'b10;

  function automatic logic is_mem_class(input iclass_t cls);
    return (cls == CL_LOAD) || (cls == CL_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_decode: combinational IR -> class, ExtOp, illegal, ebreak    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ctrl_decode
  import npc_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output iclass_t     o_class,
  output logic [2:0]  o_ext_op,
  output logic        o_illegal,
  output logic        o_is_ebreak
);

  iclass_t    w_class;
  logic [2:0] w_ext_op;
  logic       w_is_ebreak;

  always_comb begin
    w_class  = CL_NONE;
    w_ext_op = C_EXT_I;
    unique case (i_ir[6:0])
      C_OPC_LUI:    begin w_class = CL_LUI;    w_ext_op = C_EXT_U; end
      C_OPC_AUIPC:  begin w_class = CL_AUIPC;  w_ext_op = C_EXT_U; end
      C_OPC_JAL:    begin w_class = CL_JAL;    w_ext_op = C_EXT_J; end
      C_OPC_JALR:   begin w_class = CL_JALR;   w_ext_op = C_EXT_I; end
      C_OPC_BRANCH: begin w_class = CL_BRANCH; w_ext_op = C_EXT_B; end
      C_OPC_LOAD:   begin w_class = CL_LOAD;   w_ext_op = C_EXT_I; end
      C_OPC_STORE:  begin w_class = CL_STORE;  w_ext_op = C_EXT_S; end
      C_OPC_OPIMM:  begin w_class = CL_OPIMM;  w_ext_op = C_EXT_I; end
      C_OPC_OP:     begin w_class = CL_OP;     w_ext_op = C_EXT_I; end
      default:      begin w_class = CL_NONE;   w_ext_op = C_EXT_I; end
    endcase
  end

  // ebreak shares the SYSTEM opcode with instructions we reject
  assign w_is_ebreak = (i_ir == C_INSTR_EBREAK);

  assign o_class     = w_class;
  assign o_ext_op    = w_ext_op;
  assign o_is_ebreak = w_is_ebreak;
  assign o_illegal   = (w_class == CL_NONE) && !w_is_ebreak;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_ctrl: RV32I multicycle control FSM with IR register    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module multicycle_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] Instr,
  output logic                  IFetchReq,
  input  logic                  IFetchAck,
  output logic [DATA_WIDTH-1:0] IR,
  output logic [2:0]            ExtOp,
  output logic                  DMemReq,
  output logic                  DMemWe,
  input  logic                  DMemAck,
  input  logic                  BranchTaken,
  output logic                  RegWrite,
  output logic [1:0]            WbSel,
  output logic                  PCWrite,
  output logic [1:0]            PCSel,
  output logic                  Illegal,
  output logic                  Halted
);

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_ir;
  iclass_t               r_class;
  logic                  r_illegal;

  iclass_t               w_dec_class;
  logic [2:0]            w_dec_ext_op;
  logic                  w_dec_illegal;
  logic                  w_dec_ebreak;

  ctrl_decode u_decode (
    .i_ir        (r_ir[31:0]),
    .o_class     (w_dec_class),
    .o_ext_op    (w_dec_ext_op),
    .o_illegal   (w_dec_illegal),
    .o_is_ebreak (w_dec_ebreak)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // IR only moves on the fetch ack, so ExtOp is stable until retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_class   <= CL_NONE;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && IFetchAck) begin
        r_ir <= Instr;
      end
      if (r_state == ST_DECODE) begin
        r_class <= w_dec_class;
        if (w_dec_illegal) begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    IFetchReq = 1'b0;
    DMemReq   = 1'b0;
    DMemWe    = 1'b0;
    RegWrite  = 1'b0;
    PCWrite   = 1'b0;
    WbSel     = C_WB_ALU;
    PCSel     = C_PC_PLUS4;
    unique case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        IFetchReq = 1'b1;
        if (IFetchAck) begin
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_dec_ebreak || w_dec_illegal) begin
          w_next = ST_HALT;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mem_class(r_class)) begin
          w_next = ST_MEM;
        end else if (r_class == CL_BRANCH) begin
          PCWrite = 1'b1;
          PCSel   = BranchTaken ? C_PC_REL : C_PC_PLUS4;
          w_next  = ST_FETCH;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        DMemReq = 1'b1;
        DMemWe  = (r_class == CL_STORE);
        if (DMemAck) begin
          if (r_class == CL_STORE) begin
            PCWrite = 1'b1;
            PCSel   = C_PC_PLUS4;
            w_next  = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        w_next   = ST_FETCH;
        unique case (r_class)
          CL_LOAD: WbSel = C_WB_LOAD;
          CL_JAL:  begin WbSel = C_WB_PC4; PCSel = C_PC_REL;  end
          CL_JALR: begin WbSel = C_WB_PC4; PCSel = C_PC_JALR; end
          default: begin WbSel = C_WB_ALU; PCSel = C_PC_PLUS4; end
        endcase
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign IR      = r_ir;
  assign ExtOp   = w_dec_ext_op;
  assign Illegal = r_illegal;
  assign Halted  = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Bench for multicycle_ctrl: directed plan items plus random instruction
// streams checked per instruction against an opcode-level timing model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = '0;
  logic        IFetchReq;
  logic        IFetchAck = 1'b0;
  logic [31:0] IR;
  logic [2:0]  ExtOp;
  logic        DMemReq;
  logic        DMemWe;
  logic        DMemAck = 1'b0;
  logic        BranchTaken = 1'b0;
  logic        RegWrite;
  logic [1:0]  WbSel;
  logic        PCWrite;
  logic [1:0]  PCSel;
  logic        Illegal;
  logic        Halted;

  int vectors = 0;
  int miscompares = 0;

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Instr       (Instr),
    .IFetchReq   (IFetchReq),
    .IFetchAck   (IFetchAck),
    .IR          (IR),
    .ExtOp       (ExtOp),
    .DMemReq     (DMemReq),
    .DMemWe      (DMemWe),
    .DMemAck     (DMemAck),
    .BranchTaken (BranchTaken),
    .RegWrite    (RegWrite),
    .WbSel       (WbSel),
    .PCWrite     (PCWrite),
    .PCSel       (PCSel),
    .Illegal     (Illegal),
    .Halted      (Halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per-instruction expectations straight from the opcode table
  typedef struct {
    int         base;
    bit         mem;
    bit         store;
    bit         rw;
    logic [1:0] wb;
    logic [1:0] pc;
    logic [2:0] ext;
  } expect_t;

  function automatic expect_t model(input logic [31:0] ins, input bit bt);
    expect_t e;
    e.base = 4; e.mem = 0; e.store = 0; e.rw = 1;
    e.wb = 2'b00; e.pc = 2'b00; e.ext = 3'b000;
    case (ins[6:0])
      7'b0110111, 7'b0010111: e.ext = 3'b001;
      7'b1101111: begin e.ext = 3'b100; e.wb = 2'b10; e.pc = 2'b01; end
      7'b1100111: begin e.wb = 2'b10; e.pc = 2'b10; end
      7'b1100011: begin e.ext = 3'b011; e.base = 3; e.rw = 0; e.pc = bt ? 2'b01 : 2'b00; end
      7'b0000011: begin e.base = 5; e.mem = 1; e.wb = 2'b01; end
      7'b0100011: begin e.ext = 3'b010; e.base = 4; e.mem = 1; e.store = 1; e.rw = 0; end
      default: ;
    endcase
    return e;
  endfunction

  // Entered just after a clock edge with the DUT requesting a fetch;
  // returns just after the edge on which the next fetch begins.
  task automatic run_instr(input string nm, input logic [31:0] ins,
                           input int fw, input int dw, input bit bt);
    expect_t    e;
    int         cyc = 0, fcnt = 0, dcnt = 0, nfreq = 0, ndreq = 0;
    int         nreg = 0, npc = 0, nboth = 0, ext_bad = 0, ir_bad = 0, we_bad = 0;
    logic [1:0] wbs = 2'b11, pcs = 2'b11;
    bit         done = 0;
    e = model(ins, bt);
    while (!done) begin
      BranchTaken = bt;
      if (IFetchReq) begin
        IFetchAck = (fcnt == fw);
        Instr     = (fcnt == fw) ? ins : $urandom;
        fcnt++; nfreq++;
      end else begin
        IFetchAck = 1'($urandom_range(0, 1));
        Instr     = $urandom;
      end
      if (DMemReq) begin
        DMemAck = (dcnt == dw);
        dcnt++; ndreq++;
        if (DMemWe !== e.store) we_bad++;
      end else begin
        DMemAck = 1'($urandom_range(0, 1));
      end
      #1;
      if (RegWrite) begin nreg++; wbs = WbSel; end
      if (PCWrite) begin npc++; pcs = PCSel; end
      if (RegWrite && PCWrite) nboth++;
      if (fcnt > fw && !IFetchReq) begin
        if (ExtOp !== e.ext) ext_bad++;
        if (IR !== ins) ir_bad++;
      end
      @(posedge clk); #1;
      cyc++;
      if ((IFetchReq && fcnt > fw) || Halted || cyc >= 60) done = 1;
    end
    check({nm, " cycles"}, cyc, e.base + fw + (e.mem ? dw : 0));
    check({nm, " ifetch_req_cycles"}, nfreq, fw + 1);
    check({nm, " dmem_req_cycles"}, ndreq, e.mem ? dw + 1 : 0);
    check({nm, " dmem_we_errs"}, we_bad, 0);
    check({nm, " regwrite_pulses"}, nreg, e.rw);
    if (e.rw) check({nm, " wbsel"}, wbs, e.wb);
    check({nm, " pcwrite_pulses"}, npc, 1);
    check({nm, " pcsel"}, pcs, e.pc);
    check({nm, " pc_and_reg_together"}, nboth, e.rw);
    check({nm, " extop_errs"}, ext_bad, 0);
    check({nm, " ir_errs"}, ir_bad, 0);
    check({nm, " illegal"}, Illegal, 0);
  endtask

  task automatic run_halt(input string nm, input logic [31:0] ins, input bit exp_ill);
    int cyc = 0, strobes = 0, late_req = 0;
    bit acked = 0;
    while (!Halted && cyc < 20) begin
      if (IFetchReq && !acked) begin
        IFetchAck = 1'b1; Instr = ins; acked = 1;
      end else begin
        IFetchAck = 1'b0; Instr = $urandom;
      end
      DMemAck = 1'b0;
      #1;
      if (RegWrite || PCWrite || DMemReq) strobes++;
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " cycles_to_halt"}, cyc, 2);
    check({nm, " halted"}, Halted, 1);
    check({nm, " illegal"}, Illegal, exp_ill);
    repeat (6) begin
      IFetchAck = 1'($urandom_range(0, 1));
      DMemAck   = 1'($urandom_range(0, 1));
      Instr     = $urandom;
      #1;
      if (IFetchReq) late_req++;
      if (RegWrite || PCWrite || DMemReq) strobes++;
      @(posedge clk); #1;
    end
    check({nm, " ifetch_after_halt"}, late_req, 0);
    check({nm, " strobes"}, strobes, 0);
    check({nm, " still_halted"}, Halted, 1);
  endtask

  task automatic release_reset(input string nm);
    IFetchAck = 1'b0; DMemAck = 1'b0; BranchTaken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({nm, " idle_no_req"}, IFetchReq, 0);
    @(posedge clk); #1;
    check({nm, " fetch_req_2nd_cycle"}, IFetchReq, 1);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset(nm);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin : stim
    logic [6:0]  opc [9];
    logic [31:0] r;
    int          mcyc;
    opc = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst IR", IR, 0);
    check("rst ExtOp", ExtOp, 0);
    check("rst IFetchReq", IFetchReq, 0);
    check("rst DMemReq", DMemReq, 0);
    check("rst RegWrite", RegWrite, 0);
    check("rst PCWrite", PCWrite, 0);
    check("rst WbSel", WbSel, 0);
    check("rst PCSel", PCSel, 0);
    check("rst Illegal", Illegal, 0);
    check("rst Halted", Halted, 0);
    release_reset("boot");

    // Directed plan items
    run_instr("addi", 32'h0050_0093, 2, 0, 0);
    run_instr("lw",   32'h0000_A103, 0, 3, 0);
    run_instr("sw",   32'h0011_2023, 0, 0, 0);
    run_instr("beq_t", 32'h0000_0463, 0, 0, 1);
    run_instr("beq_n", 32'h0000_0463, 1, 0, 0);
    run_instr("jal",  32'h0080_00EF, 0, 0, 0);
    run_instr("jalr", 32'h0000_80E7, 0, 0, 0);
    run_instr("lui",  32'h1234_50B7, 0, 0, 0);

    // Random instruction stream
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      run_instr($sformatf("rnd%0d", i), {r[31:7], opc[$urandom_range(0, 8)]},
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while a load waits in MEM
    do_reset("pre_mem_rst");
    mcyc = 0;
    while (!DMemReq && mcyc < 10) begin
      IFetchAck = IFetchReq; Instr = 32'h0000_A103; DMemAck = 1'b0;
      @(posedge clk); #1;
      mcyc++;
    end
    check("mem_rst reached_mem", DMemReq, 1);
    rst_n = 1'b0;
    DMemAck = 1'b1;
    #1;
    check("mem_rst DMemReq", DMemReq, 0);
    check("mem_rst PCWrite", PCWrite, 0);
    check("mem_rst RegWrite", RegWrite, 0);
    check("mem_rst IR", IR, 0);
    @(posedge clk); #1;
    check("mem_rst held_idle", IFetchReq, 0);
    release_reset("mem_rst");
    run_instr("post_rst_addi", 32'h0050_0093, 0, 0, 0);

    // Halt and illegal
    run_halt("ebreak", 32'h0010_0073, 0);
    do_reset("pre_illegal");
    run_halt("illegal", 32'hFFFF_FFFF, 1);
    do_reset("post_illegal");
    check("post_illegal Illegal_cleared", Illegal, 0);
    check("post_illegal Halted_cleared", Halted, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
